// File: rtl/arb_pkg.sv
// Shared encodings for the core/DMA memory arbiter and its read-return path.
package arb_pkg;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  typedef enum logic {
    ARB      = 1'b0,
    DMA_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-latency {valid, owner} shift register that tells the arbiter which
// master the memory read data at its input belongs to.
module rd_tag_pipe
  import arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_valid,
  input  owner_e push_owner,
  output logic   tail_valid,
  output owner_e tail_owner
);

  logic [MEM_LATENCY-1:0] valid_q;
  owner_e                 owner_q [MEM_LATENCY];

  // Clearing the valid bits on reset drops every read that was in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) owner_q[i] <= OWNER_CPU;
    end else begin
      valid_q[0] <= push_valid;
      owner_q[0] <= push_owner;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign tail_valid = valid_q[MEM_LATENCY-1];
  assign tail_owner = owner_q[MEM_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// multicycle core and a DMA/debug master, with a bounded DMA burst lock.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_LOCK    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [DATA_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic              dma_lock_i,
  input  logic [DATA_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  arb_state_e       state_q, state_d;
  owner_e           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_exit;
  logic             tail_valid;
  owner_e           tail_owner;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB;
      last_q  <= OWNER_DMA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle that forces the CPU back in grants nobody, so a lock never
  // yields more than MAX_LOCK locked beats while the CPU waits.
  always_comb begin
    cpu_gnt_o  = 1'b0;
    dma_gnt_o  = 1'b0;
    force_exit = 1'b0;
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    if (rst_ni) begin
      case (state_q)
        ARB: begin
          if (cpu_req_i && (!dma_req_i || last_q == OWNER_DMA)) cpu_gnt_o = 1'b1;
          else if (dma_req_i)                                     dma_gnt_o = 1'b1;
          if (dma_gnt_o && dma_lock_i) begin
            state_d = DMA_LOCK;
            cnt_d   = '0;
          end
        end
        DMA_LOCK: begin
          force_exit = cpu_req_i && (cnt_q == CNT_MAX);
          dma_gnt_o  = dma_req_i && !force_exit;
          if (cpu_req_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
          if (force_exit || (dma_gnt_o && !dma_lock_i)) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
      if (cpu_gnt_o)                    last_d = OWNER_CPU;
      else if (dma_gnt_o || force_exit) last_d = OWNER_DMA;
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (cpu_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end else if (dma_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = dma_we_i;
      mem_addr_o  = dma_addr_i;
      mem_wdata_o = dma_wdata_i;
    end
  end

  rd_tag_pipe #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_rd_tag_pipe (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_valid (mem_en_o && !mem_we_o),
    .push_owner (dma_gnt_o ? OWNER_DMA : OWNER_CPU),
    .tail_valid (tail_valid),
    .tail_owner (tail_owner)
  );

  assign cpu_rvalid_o = rst_ni && tail_valid && (tail_owner == OWNER_CPU);
  assign dma_rvalid_o = rst_ni && tail_valid && (tail_owner == OWNER_DMA);
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
  assign dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (MEM_LATENCY 1, 3, 2 with
// MAX_LOCK 4) share one stimulus stream, each behind a small memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic [2:0]       cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [2:0][31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    logic [31:0] pipe [4];

    mem_arbiter #(
      .DATA_W(32),
      .MEM_LATENCY(LAT),
      .MAX_LOCK(4)
    ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cpu_req_i   (cpu_req),
      .cpu_we_i    (cpu_we),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_gnt_o   (cpu_gnt[g]),
      .cpu_rvalid_o(cpu_rvalid[g]),
      .cpu_rdata_o (cpu_rdata[g]),
      .dma_req_i   (dma_req),
      .dma_we_i    (dma_we),
      .dma_lock_i  (dma_lock),
      .dma_addr_i  (dma_addr),
      .dma_wdata_i (dma_wdata),
      .dma_gnt_o   (dma_gnt[g]),
      .dma_rvalid_o(dma_rvalid[g]),
      .dma_rdata_o (dma_rdata[g]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g])
    );

    // Memory model: read data emerges LAT cycles after the enable.
    always @(posedge clk) begin
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem_data(mem_addr[g]) : 32'h0;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge, then waits for the
  // falling edge so the combinational outputs can be sampled.
  task automatic apply_stimulus(input logic cr, input logic cw, input logic [31:0] ca,
                                input logic [31:0] cwd, input logic dr, input logic dw,
                                input logic dl, input logic [31:0] da);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cwd;
    dma_req   = dr;
    dma_we    = dw;
    dma_lock  = dl;
    dma_addr  = da;
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic with_req);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    cpu_req   = with_req;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h30;
    cpu_wdata = 32'h0;
    dma_req   = with_req;
    dma_we    = 1'b0;
    dma_lock  = with_req;
    dma_addr  = 32'h34;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_cpu_gnt%0d", g), cpu_gnt[g], 0);
      check($sformatf("rst_dma_gnt%0d", g), dma_gnt[g], 0);
      check($sformatf("rst_mem_en%0d", g), mem_en[g], 0);
      check($sformatf("rst_cpu_rvalid%0d", g), cpu_rvalid[g], 0);
      check($sformatf("rst_dma_rvalid%0d", g), dma_rvalid[g], 0);
      check($sformatf("rst_cpu_rdata%0d", g), cpu_rdata[g], 0);
      check($sformatf("rst_dma_rdata%0d", g), dma_rdata[g], 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0;
    dma_wdata = 32'hD0D0D0D0;

    apply_reset(1'b1);
    apply_reset(1'b1);

    // Single CPU read of 0x10, latency 1
    apply_stimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    check("t1_cpu_gnt", cpu_gnt[0], 1);
    check("t1_mem_en", mem_en[0], 1);
    check("t1_mem_addr", mem_addr[0], 32'h10);
    check("t1_dma_rvalid_c0", dma_rvalid[0], 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_cpu_rvalid", cpu_rvalid[0], 1);
    check("t1_cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
    check("t1_dma_rvalid_c1", dma_rvalid[0], 0);
    check("t1_dma_rdata", dma_rdata[0], 0);
    check("t1_idle_mem_en", mem_en[0], 0);
    check("t1_idle_mem_addr", mem_addr[0], 0);

    // Both masters reading continuously: grants alternate, returns follow
    apply_reset(1'b0);
    for (int k = 0; k < 7; k++) begin
      if (k < 6) apply_stimulus(1, 0, 32'h40, 0, 1, 0, 0, 32'h80);
      else       apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      if (k < 6) begin
        check($sformatf("t2_cpu_gnt_c%0d", k), cpu_gnt[0], (k % 2) == 0);
        check($sformatf("t2_dma_gnt_c%0d", k), dma_gnt[0], (k % 2) == 1);
      end
      if (k > 0) begin
        check($sformatf("t2_cpu_rvalid_c%0d", k), cpu_rvalid[0], ((k - 1) % 2) == 0);
        check($sformatf("t2_dma_rvalid_c%0d", k), dma_rvalid[0], ((k - 1) % 2) == 1);
        check($sformatf("t2_cpu_rdata_c%0d", k), cpu_rdata[0],
              ((k - 1) % 2 == 0) ? 32'hC0DE0040 : 32'h0);
        check($sformatf("t2_dma_rdata_c%0d", k), dma_rdata[0],
              ((k - 1) % 2 == 1) ? 32'hC0DE0080 : 32'h0);
      end
    end

    // DMA lock with the CPU waiting: entry + 4 locked beats, then CPU
    apply_reset(1'b0);
    apply_stimulus(1, 0, 32'h50, 0, 1, 0, 1, 32'h60);
    check("t3_tie_cpu_gnt", cpu_gnt[0], 1);
    apply_stimulus(1, 0, 32'h54, 0, 1, 0, 1, 32'h60);
    check("t3_entry_dma_gnt", dma_gnt[0], 1);
    check("t3_entry_cpu_gnt", cpu_gnt[0], 0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 0, 32'h54, 0, 1, 0, 1, 32'h64 + 4 * i);
      check($sformatf("t3_lock_dma_gnt%0d", i), dma_gnt[0], 1);
      check($sformatf("t3_lock_cpu_gnt%0d", i), cpu_gnt[0], 0);
    end
    apply_stimulus(1, 0, 32'h54, 0, 1, 0, 1, 32'h74);
    check("t3_force_dma_gnt", dma_gnt[0], 0);
    check("t3_force_mem_en", mem_en[0], 0);
    apply_stimulus(1, 0, 32'h54, 0, 1, 0, 1, 32'h74);
    check("t3_after_cpu_gnt", cpu_gnt[0], 1);
    check("t3_after_dma_gnt", dma_gnt[0], 0);

    // Three-beat locked DMA burst with no CPU traffic
    apply_reset(1'b0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 32'h70);
    check("t4_beat0_gnt", dma_gnt[0], 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 32'h74);
    check("t4_beat1_gnt", dma_gnt[0], 1);
    check("t4_beat0_rdata", dma_rdata[0], 32'hC0DE0070);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 32'h78);
    check("t4_beat2_gnt", dma_gnt[0], 1);
    check("t4_beat1_rdata", dma_rdata[0], 32'hC0DE0074);
    apply_stimulus(1, 0, 32'h7C, 0, 1, 0, 0, 32'h80);
    check("t4_arb_cpu_gnt", cpu_gnt[0], 1);
    check("t4_arb_dma_gnt", dma_gnt[0], 0);
    check("t4_beat2_rdata", dma_rdata[0], 32'hC0DE0078);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_cpu_rvalid", cpu_rvalid[0], 1);
    check("t4_cpu_rdata", cpu_rdata[0], 32'hC0DE007C);

    // Latency 3: DMA read, CPU write, DMA read
    apply_reset(1'b0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 32'h24);
    check("t5_dma_gnt0", dma_gnt[1], 1);
    apply_stimulus(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0);
    check("t5_cpu_gnt", cpu_gnt[1], 1);
    check("t5_mem_we", mem_we[1], 1);
    check("t5_mem_addr", mem_addr[1], 32'h20);
    check("t5_mem_wdata", mem_wdata[1], 32'h12345678);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 32'h28);
    check("t5_dma_gnt2", dma_gnt[1], 1);
    check("t5_early_rvalid", dma_rvalid[1], 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_c3_dma_rvalid", dma_rvalid[1], 1);
    check("t5_c3_dma_rdata", dma_rdata[1], 32'hC0DE0024);
    check("t5_c3_cpu_rvalid", cpu_rvalid[1], 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_c4_dma_rvalid", dma_rvalid[1], 0);
    check("t5_c4_cpu_rvalid", cpu_rvalid[1], 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_c5_dma_rvalid", dma_rvalid[1], 1);
    check("t5_c5_dma_rdata", dma_rdata[1], 32'hC0DE0028);
    check("t5_c5_cpu_rvalid", cpu_rvalid[1], 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_c6_dma_rvalid", dma_rvalid[1], 0);

    // Latency 2: reset one cycle after a granted CPU read drops its return
    apply_reset(1'b0);
    apply_stimulus(1, 0, 32'h30, 0, 0, 0, 0, 0);
    check("t6_cpu_gnt", cpu_gnt[2], 1);
    apply_reset(1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_c2_cpu_rvalid", cpu_rvalid[2], 0);
    check("t6_c2_cpu_rdata", cpu_rdata[2], 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_c3_cpu_rvalid", cpu_rvalid[2], 0);
    check("t6_c3_dma_rvalid", dma_rvalid[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous data/instruction memory between two masters: the multicycle core (fetch, load and store) and a DMA/debug master.
- Uses round-robin arbitration with a single-cycle grant.
- Supports an optional DMA burst lock, bounded by a starvation limit.
- Routes read data back to the issuing master through a fixed-latency tag pipeline.
- Sits between the core's memory port (addr/we/wdata/rdata) and the memory macro.

Parameters:
- DATA_W, 32, data and address width.
- MEM_LATENCY, 1, cycles from memory enable to valid rdata. Legal range is 1..4.
- MAX_LOCK, 16, maximum consecutive locked DMA cycles while the CPU is requesting.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset, synchronous and active-low.
- cpu_req_i  in  1  CPU access request.
- cpu_we_i  in  1  CPU write enable.
- cpu_addr_i  in  DATA_W  CPU byte address.
- cpu_wdata_i  in  DATA_W  CPU write data.
- cpu_gnt_o  out  1  CPU access accepted this cycle.
- cpu_rvalid_o  out  1  CPU read data valid.
- cpu_rdata_o  out  DATA_W  CPU read data.
- dma_req_i  in  1  DMA access request.
- dma_we_i  in  1  DMA write enable.
- dma_lock_i  in  1  DMA requests ownership for its next access.
- dma_addr_i  in  DATA_W  DMA byte address.
- dma_wdata_i  in  DATA_W  DMA write data.
- dma_gnt_o  out  1  DMA access accepted this cycle.
- dma_rvalid_o  out  1  DMA read data valid.
- dma_rdata_o  out  DATA_W  DMA read data.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  DATA_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en_o.

Behaviour:
- Reset: while rst_ni=0 at a clock edge, the following are cleared:
  - state <= ARB, last_winner <= DMA, lock counter <= 0;
  - tag pipeline valid bits <= 0.
- Outputs during reset cycles:
  - gnt, rvalid and mem_en_o are all 0;
  - rdata outputs are 0.
- Grant timing: grant is combinational in the same cycle as the request. Memory signals are muxed from the winner in that cycle.
  - mem_en_o = cpu_gnt_o | dma_gnt_o.
  - At most one gnt is high per cycle.
- Masters hold req, addr, we and wdata stable until gnt.
- State ARB, arbitration:
  - Only one master requesting: that master wins.
  - Both requesting: the master that is not last_winner wins.
  - last_winner updates on every grant.
- Entering DMA_LOCK: if DMA wins in ARB with dma_lock_i=1, the next state is DMA_LOCK and the counter is cleared.
- State DMA_LOCK, behaviour in the current cycle:
  - cpu_gnt_o = 0;
  - dma_gnt_o = dma_req_i;
  - the counter increments each cycle in which cpu_req_i=1, saturating at MAX_LOCK.
- Exiting DMA_LOCK, both cases return to ARB on the next cycle:
  - normal exit: a DMA grant with dma_lock_i=0;
  - forced exit: counter == MAX_LOCK and cpu_req_i=1. last_winner is set to DMA so the CPU wins the next tie. DMA may re-lock only through a fresh ARB win.
- Read return:
  - Each granted read pushes {valid=1, owner} into a MEM_LATENCY-deep shift register.
  - A write pushes valid=0 and completes at grant.
  - At the tail, rvalid is asserted only for the owner. rdata is steered to that owner and is 0 for the other master.
- Back-to-back accesses: one access per cycle is allowed, including alternating owners. Returns arrive in issue order.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced after reset for pre-reset accesses.
- No request: mem_en_o=0, mem_we_o=0. Address and wdata drive 0.

Decomposition:
- Shared package arb_pkg holds:
  - owner encoding OWNER_CPU=1'b0, OWNER_DMA=1'b1;
  - state encodings ARB=1'b0, DMA_LOCK=1'b1.
- Sub-module rd_tag_pipe (parameter MEM_LATENCY): a shift register of {valid, owner}. The fixed-latency return path is reusable for a future I/D split.

Test Plan:
- Single CPU read of address 0x10 (memory returns 0xDEADBEEF), MEM_LATENCY=1:
  - cpu_gnt_o=1 in cycle 0;
  - cpu_rvalid_o=1 with rdata 0xDEADBEEF in cycle 1;
  - dma_rvalid_o=0 throughout.
- Both masters request reads continuously for 6 cycles after reset: grants alternate CPU, DMA, CPU, DMA, CPU, DMA, and each rvalid arrives at its owner 1 cycle later.
- DMA wins with dma_lock_i=1 while the CPU requests continuously, MAX_LOCK=4:
  - DMA is granted for exactly 4 locked cycles plus the entry cycle;
  - the forced exit then gives the CPU the next grant.
- DMA locks a 3-beat burst (dma_lock_i=1, 1, 0) with no CPU request: 3 consecutive dma_gnt_o, after which the state returns to ARB.
- MEM_LATENCY=3 with interleaved CPU write 0x20 and DMA reads 0x24 and 0x28: only the two DMA rvalids fire, 3 cycles after each grant, in order.
- rst_ni asserted 1 cycle after a granted CPU read (MEM_LATENCY=2): no cpu_rvalid_o ever appears, and all outputs are 0 during reset.
